// File: rtl/dmem_sram_pkg.sv
// Shared data-bus definitions for dmem_sram and the other data-bus slaves.
// Includes the byte width, the reset and write-enable polarity names, the zero word,
// and the data-bus response encoding. A response is either OKAY or ERR; ERR means an out-of-range word.
package dmem_sram_pkg;

  localparam int          ByteWidth    = 8;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        RstDisable   = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  // Value carried on rsp_err.
  typedef enum logic {
    RSP_OKAY = 1'b0,
    RSP_ERR  = 1'b1
  } dbus_rsp_e;

endpackage

// File: rtl/dmem_sram_if.sv
// Data-bus request/response channel between the load/store unit (master) and a data slave.
interface dmem_sram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// One byte lane of the data memory. It is a DEPTH x 8 array with a write strobe and a registered read.
// The read register changes only on a read strobe.
// The response path can therefore hold the last read value for as long as it is stalled.
module dmem_bank
  import dmem_sram_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [ByteWidth-1:0] wdata,
  output logic [ByteWidth-1:0] rdata
);

  logic [ByteWidth-1:0] mem_reg [DEPTH];
  logic [ByteWidth-1:0] rdata_reg;

  // Array write and registered array read; neither is reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_sram.sv
// Single-port data memory with per-byte write enables and a synchronous read.
// It uses a valid/ready request/response handshake, and every accepted request returns one response, in order.
// Optional feature macro: DMEM_OUT_REG_EN.
// When it is defined, a second output register is added, latency becomes 2, and the two stages form an in-order pipeline.
// When it is undefined, there is a single response stage with latency 1.
module dmem_sram
  import dmem_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_sram_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int OFF  = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] word_idx;
  logic [AW-1:0]     bank_addr;
  logic [DATA_W-1:0] bank_rdata;
  logic              in_range;
  logic              accept;
  logic              is_write;

  assign word_idx  = bus.req_addr >> OFF;
  assign in_range  = word_idx < ADDR_W'(DEPTH);
  assign bank_addr = word_idx[AW-1:0];
  // The request side is ignored during the reset cycle, so a request cannot touch the array then.
  assign accept    = bus.req_valid && bus.req_ready && (rst == RstDisable);
  assign is_write  = (bus.req_we == WriteEnable);

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    dmem_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk   (clk),
      .we    (accept && is_write && in_range && bus.req_be[gi]),
      .re    (accept && (bus.req_we == WriteDisable) && in_range),
      .addr  (bank_addr),
      .wdata (bus.req_wdata[gi*ByteWidth +: ByteWidth]),
      .rdata (bank_rdata[gi*ByteWidth +: ByteWidth])
    );
  end

`ifdef DMEM_OUT_REG_EN
  // Stage 1 holds the array read register. Stage 2 is the response register.
  logic              s1_valid_reg, s1_err_reg, s1_rd_reg;
  logic              s2_valid_reg, s2_err_reg;
  logic [DATA_W-1:0] s2_data_reg;
  logic              s2_load;

  // Stage 1 moves forward whenever stage 2 is empty or its response is being consumed.
  assign s2_load = s1_valid_reg && (!s2_valid_reg || bus.rsp_ready);

  // Stage 1 records the kind of each accepted access. The bank holds the read data.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_rd_reg    <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_err_reg   <= in_range ? RSP_OKAY : RSP_ERR;
      s1_rd_reg    <= !is_write && in_range;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_rd_reg    <= 1'b0;
    end
  end

  // Stage 2 is the response register. It is loaded from stage 1 and holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_data_reg  <= '0;
    end else if (s2_load) begin
      s2_valid_reg <= 1'b1;
      s2_err_reg   <= s1_err_reg;
      s2_data_reg  <= s1_rd_reg ? bank_rdata : DATA_W'(ZeroWord);
    end else if (bus.rsp_ready) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_data_reg  <= '0;
    end
  end

  assign bus.req_ready = !(s1_valid_reg && s2_valid_reg && !bus.rsp_ready);
  assign bus.rsp_valid = s2_valid_reg;
  assign bus.rsp_err   = s2_err_reg;
  assign bus.rsp_rdata = s2_data_reg;
`else
  logic rsp_valid_reg, rsp_err_reg, rsp_rd_reg;

  // Single response stage. A valid read takes its data from the bank read register, and writes or errors return zero.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rd_reg    <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= in_range ? RSP_OKAY : RSP_ERR;
      rsp_rd_reg    <= !is_write && in_range;
    end else if (bus.rsp_ready) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rd_reg    <= 1'b0;
    end
  end

  assign bus.req_ready = !rsp_valid_reg || bus.rsp_ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_rdata = rsp_rd_reg ? bank_rdata : DATA_W'(ZeroWord);
`endif

endmodule
